// File: rtl/multicycle_sequencer_if.sv
// ============================================================================
// multicycle_sequencer_if : opcode/handshake inputs and control outputs of the
// multicycle sequencer. MSEQ_RETIRE_CNT_EN adds the retired count. Rev 1.0
// ============================================================================
`default_nettype none

interface multicycle_sequencer_if;
  logic [6:0]  opcode;
  logic        mem_ready;
  logic        pc_write;
  logic        pc_write_cond;
  logic        pc_source;
  logic        ir_write;
  logic        i_or_d;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_write;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        illegal_op;
  logic        fault;
  logic [3:0]  state;
`ifdef MSEQ_RETIRE_CNT_EN
  logic [31:0] retired;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
           mem_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal_op, fault, state, retired
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
           mem_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal_op, fault, state, retired
  );
`else
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
           mem_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal_op, fault, state
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, ir_write, i_or_d, mem_read,
           mem_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
           illegal_op, fault, state
  );
`endif
endinterface

`default_nettype wire

// File: rtl/multicycle_sequencer.sv
// ============================================================================
// multicycle_sequencer : RV32 multi-cycle main control FSM (R/lw/sw/beq) with
// memory-stall timeout. MSEQ_RETIRE_CNT_EN adds a retired-instruction counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_sequencer #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 5
) (
  input  wire logic               clk,
  input  wire logic               rst,
  multicycle_sequencer_if.master  bus
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_EXEC     = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_FAULT    = 4'd10
  } state_t;

  localparam logic [6:0] c_op_rtype = 7'b0110011;
  localparam logic [6:0] c_op_lw    = 7'b0000011;
  localparam logic [6:0] c_op_sw    = 7'b0100011;
  localparam logic [6:0] c_op_beq   = 7'b1100011;
  localparam logic [CNT_W-1:0] c_wait_last =
      (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_opcode_q;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_fault;
  logic             w_wait_state;
  logic             w_timeout;

  logic       w_pc_write, w_pc_write_cond, w_pc_source, w_ir_write, w_i_or_d;
  logic       w_mem_read, w_mem_write, w_mem_to_reg, w_reg_write, w_illegal_op;
  logic [1:0] w_alu_src_a, w_alu_src_b, w_alu_op;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                        (r_state == S_MEMWRITE);
  // mem_ready on the last allowed cycle still completes normally
  assign w_timeout = (MAX_WAIT != 0) && (r_wait_cnt == c_wait_last) &&
                     !bus.mem_ready;

  always_comb begin
    w_next          = r_state;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_source     = 1'b0;
    w_ir_write      = 1'b0;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 2'b00;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_illegal_op    = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        if (bus.mem_ready) begin
          w_ir_write = 1'b1;
          w_pc_write = 1'b1;
          w_next     = S_DECODE;
        end else if (w_timeout) begin
          w_next = S_FAULT;
        end
      end
      S_DECODE: begin
        w_alu_src_b = 2'b10;
        case (bus.opcode)
          c_op_rtype:        w_next = S_EXEC;
          c_op_lw, c_op_sw:  w_next = S_MEMADDR;
          c_op_beq:          w_next = S_BRANCH;
          default: begin
            w_illegal_op = 1'b1;
            w_next       = S_FETCH;
          end
        endcase
      end
      S_MEMADDR: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_next      = (r_opcode_q == c_op_lw) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
        if (bus.mem_ready)  w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
        if (bus.mem_ready)  w_next = S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_EXEC: begin
        w_alu_src_a = 2'b01;
        w_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a     = 2'b01;
        w_alu_op        = 2'b01;
        w_pc_write_cond = 1'b1;
        w_pc_source     = 1'b1;
        w_next          = S_FETCH;
      end
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_opcode_q <= 7'd0;
      r_wait_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_opcode_q <= bus.opcode;
      if (w_next != r_state)
        r_wait_cnt <= '0;
      else if (w_wait_state && !bus.mem_ready)
        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      if (w_next == S_FAULT) r_fault <= 1'b1;
    end
  end

`ifdef MSEQ_RETIRE_CNT_EN
  logic [31:0] r_retired;
  logic        w_retire;

  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_MEMWB) || (r_state == S_MEMWRITE) ||
                     (r_state == S_ALUWB) || (r_state == S_BRANCH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_retired <= 32'd0;
    else if (w_retire) r_retired <= r_retired + 32'd1;
  end

  assign bus.retired = r_retired;
`endif

  assign bus.pc_write      = w_pc_write;
  assign bus.pc_write_cond = w_pc_write_cond;
  assign bus.pc_source     = w_pc_source;
  assign bus.ir_write      = w_ir_write;
  assign bus.i_or_d        = w_i_or_d;
  assign bus.mem_read      = w_mem_read;
  assign bus.mem_write     = w_mem_write;
  assign bus.mem_to_reg    = w_mem_to_reg;
  assign bus.reg_write     = w_reg_write;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.illegal_op    = w_illegal_op;
  assign bus.fault         = r_fault;
  assign bus.state         = r_state;

endmodule

`default_nettype wire

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle main controller FSM for the RV32 core. It steps the shared datapath (single ALU, unified memory port, register file) through fetch, decode, execute, memory and writeback phases for R-format, lw, sw and beq.
- It drives the same control-signal set as the single-cycle decoder, plus multi-cycle enables (IR/PC write, address select).
- It handshakes with memory through mem_ready.
- It detects memory-stall timeouts and illegal opcodes.

Parameters:
- MAX_WAIT, 16: maximum cycles allowed in any memory wait state before FAULT. 0 disables the timeout.
- CNT_W, 5: width of the wait counter. Must satisfy 2^CNT_W >= MAX_WAIT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  7  instruction[6:0] from the instruction register
- mem_ready  in  1  memory has completed the current read/write this cycle
- pc_write  out  1  unconditional PC update
- pc_write_cond  out  1  PC update if ALU zero (branch)
- pc_source  out  1  0 = ALU result, 1 = ALUOut register (branch target)
- ir_write  out  1  load instruction register
- i_or_d  out  1  memory address: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- mem_to_reg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- reg_write  out  1  register-file write enable
- alu_src_a  out  2  00 = PC, 01 = rs1 value
- alu_src_b  out  2  00 = rs2 value, 01 = constant 4, 10 = immediate
- alu_op  out  2  00 = add, 01 = sub/compare, 10 = funct-decoded
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- fault  out  1  sticky; memory timeout occurred
- state  out  4  current state encoding (debug)

Behaviour:
- Reset: async; state <= IDLE, opcode_q <= 0, wait counter <= 0, fault <= 0. All outputs are 0 while rst is high and in IDLE.
- States (encoding) and per-state outputs. Unlisted outputs are 0.
  - IDLE (0): no outputs. Next is FETCH.
  - FETCH (1): mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00. ir_write=pc_write=mem_ready (Mealy). Stays while !mem_ready; on mem_ready goes to DECODE.
  - DECODE (2): alu_src_a=00, alu_src_b=10, alu_op=00 (branch target into ALUOut). opcode_q <= opcode. Next state by opcode:
    - 0110011 -> EXEC
    - 0000011 or 0100011 -> MEMADDR
    - 1100011 -> BRANCH
    - any other -> FETCH, with illegal_op=1 for this cycle
  - MEMADDR (3): alu_src_a=01, alu_src_b=10, alu_op=00. Next is MEMREAD if opcode_q is lw, otherwise MEMWRITE.
  - MEMREAD (4): mem_read=1, i_or_d=1. Waits for mem_ready, then MEMWB.
  - MEMWB (5): reg_write=1, mem_to_reg=1. Next is FETCH.
  - MEMWRITE (6): mem_write=1, i_or_d=1. Waits for mem_ready, then FETCH.
  - EXEC (7): alu_src_a=01, alu_src_b=00, alu_op=10. Next is ALUWB.
  - ALUWB (8): reg_write=1, mem_to_reg=0. Next is FETCH.
  - BRANCH (9): alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=1. Next is FETCH.
  - FAULT (10): all control outputs 0, fault=1. Held until rst.
  - Encodings 11-15 go to IDLE on the next clock.
- Latency with zero wait (cycles FETCH..last state):
  - R-format: 4
  - lw: 5
  - sw: 4
  - beq: 3
  - illegal: 2
- Opcode use:
  - opcode is only sampled in DECODE.
  - Later states use opcode_q, so IR changes after DECODE have no effect.
- Wait counter (active in FETCH, MEMREAD, MEMWRITE):
  - Cleared on entry to a wait state; increments each cycle mem_ready=0.
  - If the count reaches MAX_WAIT-1 and mem_ready=0 that cycle, next state is FAULT and fault sets.
  - mem_ready=1 on that same cycle wins: a normal transition, no fault.
  - mem_ready is ignored outside wait states.
- Memory request signals are held stable throughout a wait; they deassert the cycle after mem_ready.

Optional Feature:
- Macro: MSEQ_RETIRE_CNT_EN.
- Defined:
  - Adds output retired[31:0], reset to 0.
  - Increments by 1 on every transition into FETCH from MEMWB, MEMWRITE, ALUWB or BRANCH.
  - Illegal opcodes and FAULT do not count.
  - Wraps from 0xFFFFFFFF to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset mid-MEMREAD with mem_ready held 0: assert rst -> state=0 immediately and all outputs 0. After release: IDLE, then FETCH.
- R-format (opcode 0110011), mem_ready=1 always -> states 1,2,7,8,1. reg_write=1 only in the ALUWB cycle; alu_op=10 in EXEC.
- lw (0000011) with mem_ready low 3 cycles in MEMREAD -> mem_read=1, i_or_d=1 held 4 cycles. Then MEMWB with reg_write=1, mem_to_reg=1.
- beq (1100011) -> one cycle with pc_write_cond=1, pc_source=1, alu_op=01. Then FETCH.
- Illegal opcode 0010111 -> DECODE pulses illegal_op=1 for 1 cycle, then FETCH. No reg_write or mem_write at any point.
- MAX_WAIT=4, mem_ready=0 in FETCH -> FAULT after the 4th wait cycle, fault=1 sticky. A second run with mem_ready=1 on the 4th cycle -> DECODE, fault=0.
